data_pace: RTL and testbench
============================

DATA_PACE -- requirements
Module: data_pace

Parameters
REQ-001 The block SHALL have a parameter TICK_BASE, default 100000, giving the base consume period in clk cycles (1 ms at 100 MHz).
REQ-002 The block SHALL have a parameter DEPTH, default 4, giving the FIFO entry count; only powers of two from 2 to 16 are legal.

Interface
REQ-003 clk  input  1  system clock, 100 MHz; all logic synchronous to the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 prog  input  3  consume-rate select; consume period = TICK_BASE << prog cycles.
REQ-006 modulo  input  2  source select: 0 = Fibonacci, 1 = Timer, 2 and 3 = no source.
REQ-007 fib_data  input  16  Fibonacci generator word.
REQ-008 fib_valid  input  1  fib_data valid.
REQ-009 fib_ready  output  1  Fibonacci word accepted this cycle when fib_valid is also high.
REQ-010 timer_data  input  16  Timer word.
REQ-011 timer_valid  input  1  timer_data valid.
REQ-012 timer_ready  output  1  Timer word accepted this cycle when timer_valid is also high.
REQ-013 data_2  output  16  word currently consumed; feeds the display stage.
REQ-014 tick  output  1  one-cycle consume strobe.
REQ-015 level  output  5  current FIFO occupancy, 0 to DEPTH.
REQ-016 starve  output  1  one-cycle pulse when a tick finds the FIFO empty.

Function
REQ-017 The rate counter SHALL count 0 up to (TICK_BASE << prog) - 1, assert tick for exactly that terminal cycle, and wrap to 0.
REQ-018 The rate counter SHALL be at least 32 bits wide so that prog = 7 does not overflow.
REQ-019 prog SHALL be registered every cycle; a change between the registered and current value SHALL clear the counter to 0 that cycle with tick low.
REQ-020 fib_ready SHALL be combinational: (modulo == 0) and not full and not flushing; timer_ready SHALL be the same with (modulo == 1).
REQ-021 For modulo 2 or 3, both ready outputs SHALL be 0.
REQ-022 A push SHALL occur on a clock edge where the selected source has valid and ready both high; the word SHALL be written at the write pointer.
REQ-023 A pop SHALL occur on a tick cycle with level > 0; data_2 SHALL take the head word at that edge, giving 1-cycle latency from tick to data_2.
REQ-024 data_2 SHALL hold its value between pops.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 Push and pop in the same cycle SHALL leave level unchanged and complete both operations.
REQ-027 When full, ready SHALL be low even if a pop occurs that cycle; no push-through is allowed.
REQ-028 When empty, a tick SHALL NOT pop, even if a push occurs that cycle; data_2 SHALL hold, and starve SHALL pulse on the following cycle.
REQ-029 modulo SHALL be registered; a change SHALL flush the FIFO on the next edge (pointers and level to 0) while data_2 holds.
REQ-030 Both ready outputs SHALL be low during the flush cycle.
REQ-031 After a flush the rate counter SHALL be unaffected.

Reset
REQ-032 With rst high at an edge: data_2 = 0x0000, level = 0, pointers = 0, rate counter = 0, tick = 0, starve = 0.
REQ-033 With rst high at an edge, the registered prog and modulo SHALL take their current input values, so no restart or flush follows reset.
REQ-034 While rst is high, fib_ready and timer_ready SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL discard all FIFO contents and take priority over push, pop and flush.

Verification (TICK_BASE = 4)
REQ-036 Scenario, rate: prog = 0, then prog = 2 → tick every 4 cycles, then every 16 cycles; the first post-change tick comes 16 cycles after the change.
REQ-037 Scenario, ordered delivery: modulo = 0, push fib words 1, 1, 2, 3 back-to-back → level = 4, fib_ready low; data_2 shows 1, 1, 2, 3 on successive ticks, each 1 cycle after its tick.
REQ-038 Scenario, starve: empty FIFO, tick → data_2 holds its previous value and starve pulses once; a push on the tick cycle is stored and not popped.
REQ-039 Scenario, full with simultaneous pop: level = 4, tick with fib_valid high → level = 3, no push.
REQ-040 Scenario, source switch: modulo 0→1 with level = 3 → flush next edge, level = 0, data_2 unchanged; then timer word 0x0930 pushed and shown at the next tick.
REQ-041 Scenario, reset: rst pulsed mid-stream with level = 2 → data_2 = 0x0000, level = 0, and the next tick asserts starve.

Source files
------------

// File: rtl/data_pace.sv
// Rate-paced FIFO between a selectable word source (Fibonacci or Timer) and a display consumer.
// A programmable tick pops one word per period; a source switch flushes the queue.
module data_pace #(
  parameter int unsigned TICK_BASE = 100000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  prog,
  input  logic [1:0]  modulo,
  input  logic [15:0] fib_data,
  input  logic        fib_valid,
  output logic        fib_ready,
  input  logic [15:0] timer_data,
  input  logic        timer_valid,
  output logic        timer_ready,
  output logic [15:0] data_2,
  output logic        tick,
  output logic [4:0]  level,
  output logic        starve
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]    prog_q;
  logic [1:0]    mod_q;
  logic [31:0]   cnt_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [4:0]    level_q;
  logic [15:0]   data_q;
  logic          starve_q;
  logic [15:0]   mem_q [DEPTH];

  logic [31:0] last_cnt;
  logic        restart;
  logic        flushing;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [15:0] push_data;

  always_comb begin
    last_cnt    = (32'(TICK_BASE) << prog_q) - 32'd1;
    restart     = (prog != prog_q);
    flushing    = (modulo != mod_q);
    full        = (level_q == 5'(DEPTH));
    empty       = (level_q == 5'd0);
    tick        = !rst && !restart && (cnt_q == last_cnt);
    fib_ready   = !rst && !full && !flushing && (modulo == 2'd0);
    timer_ready = !rst && !full && !flushing && (modulo == 2'd1);
    push_data   = (modulo == 2'd0) ? fib_data : timer_data;
    push        = (fib_ready && fib_valid) || (timer_ready && timer_valid);
    // An empty FIFO never pops, even when a push lands in the same cycle.
    pop         = tick && !empty && !flushing;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_q   <= prog;
      mod_q    <= modulo;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      prog_q   <= prog;
      mod_q    <= modulo;
      cnt_q    <= (restart || (cnt_q == last_cnt)) ? 32'd0 : cnt_q + 32'd1;
      starve_q <= tick && empty;
      if (flushing) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          data_q   <= mem_q[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
          2'b10:   level_q <= level_q + 5'd1;
          2'b01:   level_q <= level_q - 5'd1;
          default: level_q <= level_q;
        endcase
      end
    end
  end

  // Storage needs no reset; push is already suppressed during reset and flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign data_2 = data_q;
  assign level  = level_q;
  assign starve = starve_q;

endmodule

// File: tb/tb_data_pace.sv
// Self-checking bench for data_pace with TICK_BASE = 4, DEPTH = 4.
// Expected words are queued when a push is driven and compared when data_2 updates.
module tb_data_pace;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  prog;
  logic [1:0]  modulo;
  logic [15:0] fib_data;
  logic        fib_valid;
  logic        fib_ready;
  logic [15:0] timer_data;
  logic        timer_valid;
  logic        timer_ready;
  logic [15:0] data_2;
  logic        tick;
  logic [4:0]  level;
  logic        starve;

  always #5 clk = ~clk;

  data_pace #(
    .TICK_BASE(4),
    .DEPTH    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prog       (prog),
    .modulo     (modulo),
    .fib_data   (fib_data),
    .fib_valid  (fib_valid),
    .fib_ready  (fib_ready),
    .timer_data (timer_data),
    .timer_valid(timer_valid),
    .timer_ready(timer_ready),
    .data_2     (data_2),
    .tick       (tick),
    .level      (level),
    .starve     (starve)
  );

  typedef struct {
    logic [1:0] modulo;
    logic       chg_fib;
    logic       chg_tim;
    logic       fib;
    logic       tim;
  } vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] shown;
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles until tick is seen, starting from the current cycle (bounded).
  task automatic cycles_to_tick(output int n);
    n = 0;
    while (!tick && n < 200) begin
      step();
      n++;
    end
  endtask

  // Cycles from the current tick cycle to the next tick (bounded).
  task automatic next_tick_gap(output int n);
    step();
    n = 1;
    while (!tick && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic expect_next_pop(input string name);
    int n;
    cycles_to_tick(n);
    chk({name, "_wait"}, n, 3);
    chk({name, "_hold"}, data_2, shown);
    step();
    if (exp_q.size() == 0) begin
      chk({name, "_queue_empty"}, 1, 0);
    end else begin
      shown = exp_q.pop_front();
      chk(name, data_2, shown);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] words[4];
    words[0] = 16'd1;
    words[1] = 16'd1;
    words[2] = 16'd2;
    words[3] = 16'd3;
    vecs[0] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; prog = 3'd0; modulo = 2'd0;
    fib_data = '0; fib_valid = 1'b0; timer_data = '0; timer_valid = 1'b0;
    shown = 16'h0000;
    step();
    step();
    chk("rst_data_2", data_2, 16'h0000);
    chk("rst_level", level, 0);
    chk("rst_tick", tick, 0);
    chk("rst_starve", starve, 0);
    chk("rst_fib_ready", fib_ready, 0);
    chk("rst_timer_ready", timer_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_fib_ready", fib_ready, 1);
    chk("post_rst_timer_ready", timer_ready, 0);

    // Rate: period 4, then 16 after a prog change, then back to 4.
    cycles_to_tick(n);
    chk("first_tick", n, 3);
    next_tick_gap(n);
    chk("gap_p0_a", n, 4);
    next_tick_gap(n);
    chk("gap_p0_b", n, 4);
    step();
    prog = 3'd2;
    #1;
    chk("restart_tick_low", tick, 0);
    next_tick_gap(n);
    chk("gap_after_change", n, 16);
    next_tick_gap(n);
    chk("gap_p2", n, 16);
    step();
    prog = 3'd0;
    next_tick_gap(n);
    chk("gap_back_p0", n, 4);

    // Starve on an empty tick with a same-cycle push, then fill to full.
    for (int i = 0; i < 4; i++) begin
      fib_data  = words[i];
      fib_valid = 1'b1;
      #1;
      chk("fill_fib_ready", fib_ready, 1);
      if (i == 0) chk("starve_tick", tick, 1);
      exp_q.push_back(words[i]);
      step();
      if (i == 0) begin
        chk("starve_pulse", starve, 1);
        chk("starve_data_hold", data_2, 16'h0000);
        chk("starve_push_kept", level, 1);
      end
      if (i == 1) chk("starve_one_cycle", starve, 0);
    end
    fib_data = 16'd5;
    #1;
    chk("full_level", level, 4);
    chk("full_fib_ready", fib_ready, 0);
    chk("full_tick", tick, 1);
    step();
    fib_valid = 1'b0;
    chk("full_pop_level", level, 3);
    shown = exp_q.pop_front();
    chk("pop_0", data_2, shown);
    expect_next_pop("pop_1");
    expect_next_pop("pop_2");
    expect_next_pop("pop_3");
    chk("drained_level", level, 0);

    // Source switch with three words queued.
    cycles_to_tick(n);
    for (int i = 0; i < 3; i++) begin
      fib_data  = 16'd7 + 16'(i);
      fib_valid = 1'b1;
      step();
    end
    fib_valid   = 1'b0;
    modulo      = 2'd1;
    timer_data  = 16'h0930;
    timer_valid = 1'b1;
    #1;
    chk("flush_fib_ready", fib_ready, 0);
    chk("flush_timer_ready", timer_ready, 0);
    chk("flush_pre_level", level, 3);
    step();
    chk("flush_level", level, 0);
    chk("flush_data_hold", data_2, shown);
    chk("switch_timer_ready", timer_ready, 1);
    chk("switch_tick", tick, 1);
    exp_q.push_back(16'h0930);
    step();
    timer_valid = 1'b0;
    chk("switch_push_level", level, 1);
    chk("switch_starve", starve, 1);
    expect_next_pop("timer_pop");
    chk("timer_drained", level, 0);

    // Reset mid-stream with two words queued.
    timer_valid = 1'b1;
    timer_data  = 16'h0011;
    step();
    timer_data  = 16'h0022;
    step();
    timer_valid = 1'b0;
    chk("pre_rst_level", level, 2);
    rst = 1'b1;
    #1;
    chk("in_rst_fib_ready", fib_ready, 0);
    chk("in_rst_timer_ready", timer_ready, 0);
    step();
    rst = 1'b0;
    chk("mid_rst_data_2", data_2, 16'h0000);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_starve", starve, 0);
    cycles_to_tick(n);
    chk("post_rst_tick_wait", n, 3);
    chk("post_rst_tick_level", level, 0);
    step();
    chk("post_rst_starve", starve, 1);
    chk("post_rst_data_hold", data_2, 16'h0000);

    // Ready decode per source select, including the flush cycle.
    for (int i = 0; i < 6; i++) begin
      modulo = vecs[i].modulo;
      #1;
      chk("vec_chg_fib", fib_ready, vecs[i].chg_fib);
      chk("vec_chg_tim", timer_ready, vecs[i].chg_tim);
      step();
      chk("vec_fib", fib_ready, vecs[i].fib);
      chk("vec_tim", timer_ready, vecs[i].tim);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
